// File: rtl/mem_stage_if.sv
// Bundles the EX-side op handshake, the byte-serial memory bus and the regfile write port.
// Pure wiring, so it adds no latency.
// EX is stalled through in_ready, and each memory byte is held until mem_ack.
interface mem_stage_if #(
  parameter int ADDR_W = 17,
  parameter int REG_AW = 5
);
  // EX -> stage op handshake
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [31:0]       in_addr;
  logic [31:0]       in_data;
  logic [REG_AW-1:0] in_rd;
  logic              in_wreg;
  // byte-serial memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  // regfile write port and misalignment report
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [31:0]       wdata;
  logic              exc;
  logic [31:0]       exc_addr;

  // Environment side: EX, memory and regfile.
  modport master (
    output in_valid, in_op, in_addr, in_data, in_rd, in_wreg, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, we, waddr, wdata, exc, exc_addr
  );

  // Stage side.
  modport slave (
    input  in_valid, in_op, in_addr, in_data, in_rd, in_wreg, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, we, waddr, wdata, exc, exc_addr
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access / write-back stage: ALU pass-through, plus byte-serial little-endian loads and stores.
// ALU ops write back one cycle after accept; an n-byte load with zero-wait ack writes back n+1 cycles after accept.
// in_ready is low for the whole memory access, and each byte request is held until mem_ack.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into an exc pulse.
module mem_stage #(
  parameter int ADDR_W = 17,
  parameter int REG_AW = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,   // asynchronous, active low
  mem_stage_if.slave   bus
);
  localparam logic [3:0] OP_ALU = 4'd1, OP_LB = 4'd2, OP_LH = 4'd3, OP_LW = 4'd4, OP_LBU = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6, OP_SB = 4'd7, OP_SH = 4'd8, OP_SW = 4'd9;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       buf_q, buf_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wreg_q, wreg_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_merged;
  logic              access;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Index of the final byte of the access: the byte count minus one.
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] b);
    case (op)
      OP_LB:   return {{24{b[7]}}, b[7:0]};
      OP_LH:   return {{16{b[15]}}, b[15:0]};
      OP_LBU:  return {24'h0, b[7:0]};
      OP_LHU:  return {16'h0, b[15:0]};
      default: return b;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  logic        exc_q, exc_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction
`endif

  assign access        = (state_q == S_ACCESS);
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_req   = access;
  assign bus.mem_we    = access && is_store(op_q);
  // mod-2^ADDR_W add equals truncating the 32-bit (addr + i), so wrap-around falls out naturally
  assign bus.mem_addr  = access ? (addr_q + ADDR_W'(cnt_q)) : '0;
  assign bus.mem_wdata = (access && is_store(op_q)) ? data_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign bus.exc       = exc_q;
  assign bus.exc_addr  = exc_addr_q;
`else
  assign bus.exc       = 1'b0;
  assign bus.exc_addr  = 32'h0;
`endif

  // Buffer with the byte arriving this cycle merged in, so the last byte can be written back directly.
  always_comb begin
    buf_merged = buf_q;
    buf_merged[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
  end

  // Next-state logic: accept in IDLE, walk the bytes in ACCESS, and form the registered writeback.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    buf_d   = buf_q;
    rd_d    = rd_q;
    wreg_d  = wreg_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef MEM_MISALIGN_CHECK_EN
    exc_d      = 1'b0;
    exc_addr_d = exc_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_op == OP_ALU) begin
            we_d    = bus.in_wreg && (bus.in_rd != '0);
            waddr_d = bus.in_rd;
            wdata_d = bus.in_data;
          end else if (is_load(bus.in_op) || is_store(bus.in_op)) begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (misaligned(bus.in_op, bus.in_addr[1:0])) begin
              exc_d      = 1'b1;
              exc_addr_d = bus.in_addr;
            end else
`endif
            begin
              state_d = S_ACCESS;
              cnt_d   = 2'd0;
              op_d    = bus.in_op;
              addr_d  = bus.in_addr[ADDR_W-1:0];
              data_d  = bus.in_data;
              rd_d    = bus.in_rd;
              wreg_d  = bus.in_wreg;
              buf_d   = 32'h0;
            end
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          buf_d = buf_merged;
          if (cnt_q == last_idx(op_q)) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            if (is_load(op_q)) begin
              we_d    = wreg_q && (rd_q != '0);
              waddr_d = rd_q;
              wdata_d = extend(op_q, buf_merged);
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight without a writeback.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      buf_q   <= 32'h0;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Misalignment pulse, and the faulting address held until the next fault.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exc_q      <= 1'b0;
      exc_addr_q <= 32'h0;
    end else begin
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads and stores, address wrap, reset abort, misaligned access.
// A memory responder either acks one cycle after each request or holds ack high.
// Writebacks and memory bytes are logged with cycle stamps and then checked against hand-computed values.
module tb_mem_stage;
  localparam logic [3:0] OP_ALU = 4'd1, OP_LB = 4'd2, OP_LH = 4'd3, OP_LW = 4'd4, OP_LBU = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6, OP_SW = 4'd9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(17), .REG_AW(5)) bus ();
  mem_stage #(.ADDR_W(17), .REG_AW(5)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wait_cnt = 0;
  int rdy_viol = 0;
  int exc_cnt = 0;
  bit ack_tied = 1'b0;
  logic [31:0] exc_addr_seen = 32'h0;
  logic [7:0]  mem_model [4096];
  logic [31:0] wq_addr[$], wq_data[$], wq_cyc[$];
  logic [31:0] rq_addr[$], rq_we[$], rq_wdata[$], rq_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    rq_addr.delete(); rq_we.delete(); rq_wdata.delete(); rq_cyc.delete();
    rdy_viol = 0;
    exc_cnt = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus memory responder, evaluated away from the active edge.
  always @(negedge clk) begin
    if (bus.we) begin
      wq_addr.push_back(32'(bus.waddr));
      wq_data.push_back(bus.wdata);
      wq_cyc.push_back(cyc);
    end
    if (bus.mem_req && bus.in_ready) rdy_viol++;
    if (bus.exc) begin
      exc_cnt++;
      exc_addr_seen = bus.exc_addr;
    end
    if (!rst_n || !bus.mem_req) begin
      bus.mem_ack = ack_tied && rst_n;
      wait_cnt = 0;
    end else if (ack_tied || wait_cnt == 1) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = mem_model[bus.mem_addr[11:0]];
      rq_addr.push_back(32'(bus.mem_addr));
      rq_we.push_back(32'(bus.mem_we));
      rq_wdata.push_back(32'(bus.mem_wdata));
      rq_cyc.push_back(cyc);
      wait_cnt = 0;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt = 1;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic wreg);
    int b = 0;
    @(negedge clk);
    while (!bus.in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("issue_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_addr = addr;
    bus.in_data = data;
    bus.in_rd = rd;
    bus.in_wreg = wreg;
    acc_cyc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    @(negedge clk);
    while (!bus.in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("done_in_budget", 32'(b < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  initial begin
    ld_vec_t ld_tab[4];
    int t0;
    int b;
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'h00;
    mem_model[12'h100] = 8'h78; mem_model[12'h101] = 8'h56;
    mem_model[12'h102] = 8'h34; mem_model[12'h103] = 8'h12;
    mem_model[12'h104] = 8'hAA; mem_model[12'h105] = 8'hBB;
    mem_model[12'h010] = 8'h80;
    mem_model[12'h020] = 8'h00; mem_model[12'h021] = 8'h80;
    mem_model[12'hFFF] = 8'h34; mem_model[12'h000] = 8'h12;
    bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_addr = 32'h0; bus.in_data = 32'h0;
    bus.in_rd = 5'd0; bus.in_wreg = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_exc", 32'(bus.exc), 32'd0);
    check("rst_exc_addr", bus.exc_addr, 32'd0);
    rst_n = 1'b1;

    // Back-to-back ALU ops; the rd=0 op must not write.
    clear_logs();
    issue(OP_ALU, 32'h0, 32'h1234_5678, 5'd5, 1'b1);
    t0 = acc_cyc;
    issue(OP_ALU, 32'h0, 32'h0000_0001, 5'd6, 1'b1);
    issue(OP_ALU, 32'h0, 32'h0000_0009, 5'd0, 1'b1);
    wait_done();
    check("alu_wr_count", 32'(wq_addr.size()), 32'd2);
    check("alu_waddr0", qget(wq_addr, 0), 32'd5);
    check("alu_wdata0", qget(wq_data, 0), 32'h1234_5678);
    check("alu_waddr1", qget(wq_addr, 1), 32'd6);
    check("alu_wdata1", qget(wq_data, 1), 32'h1);
    check("alu_latency", qget(wq_cyc, 0) - 32'(t0), 32'd1);
    check("alu_b2b", qget(wq_cyc, 1) - qget(wq_cyc, 0), 32'd1);

    // LW with ack one cycle after each request.
    clear_logs();
    ack_tied = 1'b0;
    issue(OP_LW, 32'h100, 32'h0, 5'd7, 1'b1);
    wait_done();
    check("lw_bytes", 32'(rq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw_addr%0d", i), qget(rq_addr, i), 32'h100 + 32'(i));
      check($sformatf("lw_rd%0d", i), qget(rq_we, i), 32'd0);
    end
    check("lw_ready_low", 32'(rdy_viol), 32'd0);
    check("lw_wr_count", 32'(wq_addr.size()), 32'd1);
    check("lw_waddr", qget(wq_addr, 0), 32'd7);
    check("lw_wdata", qget(wq_data, 0), 32'h1234_5678);

    // Sign and zero extension of byte and halfword loads.
    ld_tab[0] = '{OP_LB,  32'h10, 32'hFFFF_FF80};
    ld_tab[1] = '{OP_LBU, 32'h10, 32'h0000_0080};
    ld_tab[2] = '{OP_LH,  32'h20, 32'hFFFF_8000};
    ld_tab[3] = '{OP_LHU, 32'h20, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      issue(ld_tab[i].op, ld_tab[i].addr, 32'h0, 5'd1, 1'b1);
      wait_done();
      check($sformatf("ext%0d_count", i), 32'(wq_data.size()), 32'd1);
      check($sformatf("ext%0d_wdata", i), qget(wq_data, 0), ld_tab[i].exp);
    end

    // Zero-wait LW: n+1 cycles from accept to write.
    clear_logs();
    ack_tied = 1'b1;
    issue(OP_LW, 32'h100, 32'h0, 5'd8, 1'b1);
    t0 = acc_cyc;
    wait_done();
    check("lw0_latency", qget(wq_cyc, 0) - 32'(t0), 32'd5);
    check("lw0_wdata", qget(wq_data, 0), 32'h1234_5678);

    // SW with ack held high: four consecutive byte writes, no regfile write.
    clear_logs();
    issue(OP_SW, 32'h200, 32'hDEAD_BEEF, 5'd3, 1'b0);
    wait_done();
    check("sw_bytes", 32'(rq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_addr%0d", i), qget(rq_addr, i), 32'h200 + 32'(i));
      check($sformatf("sw_we%0d", i), qget(rq_we, i), 32'd1);
    end
    check("sw_byte0", qget(rq_wdata, 0), 32'hEF);
    check("sw_byte1", qget(rq_wdata, 1), 32'hBE);
    check("sw_byte2", qget(rq_wdata, 2), 32'hAD);
    check("sw_byte3", qget(rq_wdata, 3), 32'hDE);
    check("sw_consecutive", qget(rq_cyc, 3) - qget(rq_cyc, 0), 32'd3);
    check("sw_no_write", 32'(wq_addr.size()), 32'd0);

`ifndef MEM_MISALIGN_CHECK_EN
    // Halfword across the top of the address space wraps to byte 0.
    clear_logs();
    issue(OP_LHU, 32'hFFFF_FFFF, 32'h0, 5'd2, 1'b1);
    wait_done();
    check("wrap_addr0", qget(rq_addr, 0), 32'h1_FFFF);
    check("wrap_addr1", qget(rq_addr, 1), 32'h0);
    check("wrap_wdata", qget(wq_data, 0), 32'h0000_1234);
`endif

    // Reset after the second byte of an LW: abort with no write, then normal operation.
    clear_logs();
    ack_tied = 1'b0;
    issue(OP_LW, 32'h100, 32'h0, 5'd10, 1'b1);
    b = 0;
    while (rq_addr.size() < 2 && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("abort_reached", 32'(rq_addr.size()), 32'd2);
    @(posedge clk);
    #1 check("abort_req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req", 32'(bus.mem_req), 32'd0);
    check("abort_we", 32'(bus.we), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", 32'(wq_addr.size()), 32'd0);
    check("abort_no_resume", 32'(rq_addr.size()), 32'd2);
    issue(OP_ALU, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1);
    wait_done();
    check("post_rst_count", 32'(wq_addr.size()), 32'd1);
    check("post_rst_waddr", qget(wq_addr, 0), 32'd9);
    check("post_rst_wdata", qget(wq_data, 0), 32'hCAFE_F00D);

    // Misaligned LW.
    clear_logs();
    ack_tied = 1'b1;
    issue(OP_LW, 32'h102, 32'h0, 5'd11, 1'b1);
    wait_done();
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_exc_count", 32'(exc_cnt), 32'd1);
    check("mis_exc_addr", exc_addr_seen, 32'h102);
    check("mis_no_req", 32'(rq_addr.size()), 32'd0);
    check("mis_no_write", 32'(wq_addr.size()), 32'd0);
`else
    check("mis_bytes", 32'(rq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("mis_addr%0d", i), qget(rq_addr, i), 32'h102 + 32'(i));
    check("mis_wdata", qget(wq_data, 0), 32'hBBAA_1234);
    check("mis_no_exc", 32'(exc_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
